// File: rtl/shift_arbiter_ctrl_pkg.sv
// Shared encodings for the shift arbiter: op codes, sequencer states and op-support helper.
// Build option: SHIFT_ROTATE_EN enables op 11 as rotate-left.
package shift_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned OP_W      = 2;
    localparam int unsigned REQ_N     = 2;

`ifdef SHIFT_ROTATE_EN
    localparam bit ROTATE_EN = 1'b1;
`else
    localparam bit ROTATE_EN = 1'b0;
`endif

    typedef enum logic [OP_W-1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROL = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    // Rotate is the only op whose support depends on the build.
    function automatic logic op_supported(input op_e op);
        return (op != OP_ROL) || ROTATE_EN;
    endfunction

endpackage

// File: rtl/shift_arbiter_ctrl_if.sv
// Request/response bundle between the two requesters, the arbiter and the result consumer.
interface shift_arbiter_ctrl_if
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
);

    logic [REQ_N-1:0] req_valid;
    logic [REQ_N-1:0] req_ready;
    logic [OP_W-1:0]  req_op0;
    logic [WIDTH-1:0] req_a0;
    logic [WIDTH-1:0] req_b0;
    logic [OP_W-1:0]  req_op1;
    logic [WIDTH-1:0] req_a1;
    logic [WIDTH-1:0] req_b1;

    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_id;
    logic             res_err;

    // Requesters plus downstream consumer.
    modport master (
        output req_valid, req_op0, req_a0, req_b0, req_op1, req_a1, req_b1, res_ready,
        input  req_ready, res_valid, res_data, res_id, res_err
    );

    // The arbiter / shifter controller.
    modport slave (
        input  req_valid, req_op0, req_a0, req_b0, req_op1, req_a1, req_b1, res_ready,
        output req_ready, res_valid, res_data, res_id, res_err
    );

endinterface

// File: rtl/shift_arbiter_ctrl_barrel_shifter.sv
// Combinational log2 barrel shifter with out-of-range override.
// Build option: SHIFT_ROTATE_EN makes op 11 a rotate; otherwise op 11 yields zero with err.
module barrel_shifter
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  op_e              op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] data_c_o,
    output logic             err_c_o
);

    logic [SHAMT_W-1:0] amt;
    logic               oor;
    logic [WIDTH-1:0]   sh;
    int unsigned        step;

    assign amt = b_i[SHAMT_W-1:0];
    assign oor = |b_i[WIDTH-1:SHAMT_W];

    // One mux stage per amount bit; stage k moves the word by 2**k.
    always_comb begin
        sh   = a_i;
        step = 0;
        for (int k = 0; k < int'(SHAMT_W); k++) begin
            step = 32'(1) << k;
            if (amt[k]) begin
                case (op_i)
                    OP_SLL:  sh = sh << step;
                    OP_SRL:  sh = sh >> step;
                    OP_SRA:  sh = WIDTH'($signed(sh) >>> step);
                    default: sh = (sh << step) | (sh >> (WIDTH - step));
                endcase
            end
        end
    end

    // Rotate ignores the upper amount bits (b mod WIDTH); shifts saturate.
    always_comb begin
        data_c_o = sh;
        err_c_o  = 1'b0;
        if (!op_supported(op_i)) begin
            data_c_o = '0;
            err_c_o  = 1'b1;
        end else if (oor && (op_i != OP_ROL)) begin
            data_c_o = (op_i == OP_SRA) ? {WIDTH{a_i[WIDTH-1]}} : '0;
        end
    end

endmodule

// File: rtl/shift_arbiter_ctrl.sv
// Round-robin arbiter and IDLE/EXEC/RESP sequencer sharing one barrel shifter between two requesters.
// Build option: SHIFT_ROTATE_EN (consumed by the shifter) enables rotate-left on op 11.
module shift_arbiter_ctrl
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input logic                 clk,
    input logic                 rst,
    shift_arbiter_ctrl_if.slave bus
);

    state_e           state_q;
    logic             rr_last_q;
    logic             id_q;
    op_e              op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    logic             res_valid_q;
    logic [WIDTH-1:0] res_data_q;
    logic             res_id_q;
    logic             res_err_q;

    logic             grant_c;
    logic [REQ_N-1:0] req_ready_c;
    logic             accept_c;
    logic [WIDTH-1:0] sh_data_c;
    logic             sh_err_c;

    // Contended cycles go to the requester that did not win last; otherwise the lone valid one wins.
    always_comb begin
        grant_c     = (&bus.req_valid) ? ~rr_last_q : bus.req_valid[1];
        req_ready_c = '0;
        if ((state_q == ST_IDLE) && (|bus.req_valid)) begin
            req_ready_c[grant_c] = 1'b1;
        end
        accept_c = |(bus.req_valid & req_ready_c);
    end

    barrel_shifter #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_shifter (
        .op_i     (op_q),
        .a_i      (a_q),
        .b_i      (b_q),
        .data_c_o (sh_data_c),
        .err_c_o  (sh_err_c)
    );

    // Sequencer, round-robin pointer, operand latches and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_last_q   <= 1'b1;
            id_q        <= 1'b0;
            op_q        <= OP_SLL;
            a_q         <= '0;
            b_q         <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= 1'b0;
            res_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_c) begin
                        op_q      <= op_e'(grant_c ? bus.req_op1 : bus.req_op0);
                        a_q       <= grant_c ? bus.req_a1 : bus.req_a0;
                        b_q       <= grant_c ? bus.req_b1 : bus.req_b0;
                        id_q      <= grant_c;
                        rr_last_q <= grant_c;
                        state_q   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    res_data_q  <= sh_data_c;
                    res_err_q   <= sh_err_c;
                    res_id_q    <= id_q;
                    res_valid_q <= 1'b1;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_id    = res_id_q;
    assign bus.res_err   = res_err_q;

endmodule

// File: tb/tb_shift_arbiter_ctrl.sv
// Self-checking bench for shift_arbiter_ctrl: vector table, corner sequences and randomized traffic
// against a plain-arithmetic reference model (honours SHIFT_ROTATE_EN).
module tb_shift_arbiter_ctrl;
    import shift_pkg::*;

    localparam int unsigned W     = 8;
    localparam int unsigned LIMIT = 20;

    typedef struct {
        logic [1:0] vm;
        logic [1:0] op0;
        logic [7:0] a0;
        logic [7:0] b0;
        logic [1:0] op1;
        logic [7:0] a1;
        logic [7:0] b1;
        logic       exp_id;
        logic [7:0] exp_d;
        logic       exp_e;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    logic model_rr;
    vec_t vecs [13];

    shift_arbiter_ctrl_if #(.WIDTH(W)) bus ();

    shift_arbiter_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string nm, input string what, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s.%s: got=%0h expected=%0h", nm, what, got, exp);
        end
    endtask

    task automatic timeout(input string nm, input string what);
        checks++;
        failures++;
        $display("FAIL %s.%s: timeout after %0d cycles", nm, what, LIMIT);
    endtask

    // Reference: shift rules computed with integer arithmetic.
    function automatic void ref_shift(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                                      output logic [7:0] d, output logic e);
        int unsigned av;
        int unsigned amt;
        int          sv;
`ifdef SHIFT_ROTATE_EN
        int unsigned r;
`endif
        av  = 32'(a);
        amt = 32'(b);
        d   = 8'h00;
        e   = 1'b0;
        case (op)
            2'b00: if (amt < 8) d = 8'((av << amt) & 32'hFF);
            2'b01: if (amt < 8) d = 8'(av >> amt);
            2'b10: begin
                sv = (av >= 128) ? int'(av) - 256 : int'(av);
                if (amt > 7) amt = 7;
                d = 8'(sv >>> amt);
            end
            default: begin
`ifdef SHIFT_ROTATE_EN
                r = amt % 8;
                d = 8'(((av << r) | (av >> (8 - r))) & 32'hFF);
`else
                e = 1'b1;
`endif
            end
        endcase
    endfunction

    task automatic do_reset();
        rst           = 1'b1;
        bus.req_valid = 2'b00;
        bus.res_ready = 1'b0;
        bus.req_op0   = 2'b00;
        bus.req_a0    = 8'h00;
        bus.req_b0    = 8'h00;
        bus.req_op1   = 2'b00;
        bus.req_a1    = 8'h00;
        bus.req_b1    = 8'h00;
        repeat (2) @(negedge clk);
        rst      = 1'b0;
        model_rr = 1'b1;
    endtask

    task automatic wait_ready(input string nm, output bit ok);
        int unsigned n = 0;
        #1;
        while (bus.req_ready == 2'b00 && n < LIMIT) begin
            @(negedge clk);
            #1;
            n++;
        end
        ok = (bus.req_ready != 2'b00);
        if (!ok) timeout(nm, "req_ready");
    endtask

    // Called on the negedge right after the accepting edge.
    task automatic wait_res(input string nm, output int unsigned n, output bit ok);
        n = 1;
        while (!bus.res_valid && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        ok = bus.res_valid;
        if (!ok) timeout(nm, "res_valid");
    endtask

    task automatic run_txn(input string nm, input vec_t v, input int unsigned rdly);
        bit          ok;
        int unsigned lat;
        @(negedge clk);
        bus.req_op0   = v.op0;
        bus.req_a0    = v.a0;
        bus.req_b0    = v.b0;
        bus.req_op1   = v.op1;
        bus.req_a1    = v.a1;
        bus.req_b1    = v.b1;
        bus.req_valid = v.vm;
        bus.res_ready = 1'b0;
        wait_ready(nm, ok);
        if (!ok) begin
            bus.req_valid = 2'b00;
            return;
        end
        check(nm, "grant", 32'(bus.req_ready), 32'(2'b01 << v.exp_id));
        @(posedge clk);
        model_rr = v.exp_id;
        @(negedge clk);
        bus.req_valid = 2'b00;
        wait_res(nm, lat, ok);
        if (!ok) return;
        check(nm, "latency", lat, 32'd2);
        check(nm, "res_id", 32'(bus.res_id), 32'(v.exp_id));
        check(nm, "res_data", 32'(bus.res_data), 32'(v.exp_d));
        check(nm, "res_err", 32'(bus.res_err), 32'(v.exp_e));
        for (int unsigned i = 0; i < rdly; i++) begin
            @(negedge clk);
            check(nm, "hold", 32'({bus.res_valid, bus.res_data}), 32'({1'b1, v.exp_d}));
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        check(nm, "release", 32'(bus.res_valid), 32'd0);
    endtask

    initial begin
        logic [7:0] rol_d;
        logic       rol_e;
        bit          ok;
        int unsigned lat;
        vec_t        v;

`ifdef SHIFT_ROTATE_EN
        rol_d = 8'h03;
        rol_e = 1'b0;
`else
        rol_d = 8'h00;
        rol_e = 1'b1;
`endif
        //           vm     op0     a0     b0      op1     a1     b1     id    data   err
        vecs[0]  = '{2'b01, OP_SLL, 8'h0F, 8'd3,   OP_SLL, 8'h00, 8'd0,  1'b0, 8'h78, 1'b0};
        vecs[1]  = '{2'b11, OP_SRA, 8'h90, 8'd9,   OP_SRL, 8'h90, 8'd9,  1'b1, 8'h00, 1'b0};
        vecs[2]  = '{2'b11, OP_SRA, 8'h90, 8'd9,   OP_SLL, 8'h01, 8'd1,  1'b0, 8'hFF, 1'b0};
        vecs[3]  = '{2'b10, OP_SLL, 8'h00, 8'd0,   OP_SRL, 8'h90, 8'd4,  1'b1, 8'h09, 1'b0};
        vecs[4]  = '{2'b01, OP_SRA, 8'h90, 8'd4,   OP_SLL, 8'h00, 8'd0,  1'b0, 8'hF9, 1'b0};
        vecs[5]  = '{2'b10, OP_SLL, 8'h00, 8'd0,   OP_SLL, 8'h81, 8'd7,  1'b1, 8'h80, 1'b0};
        vecs[6]  = '{2'b01, OP_SRL, 8'h80, 8'd7,   OP_SLL, 8'h00, 8'd0,  1'b0, 8'h01, 1'b0};
        vecs[7]  = '{2'b10, OP_SLL, 8'h00, 8'd0,   OP_SRA, 8'h7F, 8'd8,  1'b1, 8'h00, 1'b0};
        vecs[8]  = '{2'b01, OP_SLL, 8'hFF, 8'd0,   OP_SLL, 8'h00, 8'd0,  1'b0, 8'hFF, 1'b0};
        vecs[9]  = '{2'b10, OP_SLL, 8'h00, 8'd0,   OP_SRA, 8'h80, 8'hFF, 1'b1, 8'hFF, 1'b0};
        vecs[10] = '{2'b01, OP_ROL, 8'h81, 8'd1,   OP_SLL, 8'h00, 8'd0,  1'b0, rol_d, rol_e};
        vecs[11] = '{2'b10, OP_SLL, 8'h00, 8'd0,   OP_ROL, 8'h81, 8'd9,  1'b1, rol_d, rol_e};
        vecs[12] = '{2'b11, OP_SLL, 8'h01, 8'd7,   OP_SRL, 8'h80, 8'd1,  1'b0, 8'h80, 1'b0};

        // Reset state and first grant after reset.
        do_reset();
        #1;
        check("reset", "res_valid", 32'(bus.res_valid), 32'd0);
        check("reset", "res_data", 32'(bus.res_data), 32'd0);
        check("reset", "res_id", 32'(bus.res_id), 32'd0);
        check("reset", "res_err", 32'(bus.res_err), 32'd0);
        check("reset", "ready_idle", 32'(bus.req_ready), 32'd0);
        bus.req_valid = 2'b11;
        #1;
        check("reset", "first_grant", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 2'b00;

        for (int i = 0; i < 13; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i], 32'(i % 3));
        end

        // Alternation under continuous contention.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            v = '{2'b11, OP_SLL, 8'h01, 8'd1, OP_SRL, 8'h80, 8'd1, 1'(i % 2), 8'h00, 1'b0};
            v.exp_d = v.exp_id ? 8'h40 : 8'h02;
            run_txn($sformatf("alt%0d", i), v, 0);
        end

        // Backpressure: result held, no accepts until the result handshake.
        do_reset();
        @(negedge clk);
        bus.req_op0   = OP_SLL;
        bus.req_a0    = 8'h0F;
        bus.req_b0    = 8'd1;
        bus.req_op1   = OP_SRL;
        bus.req_a1    = 8'hF0;
        bus.req_b1    = 8'd4;
        bus.req_valid = 2'b01;
        wait_ready("bp", ok);
        if (ok) begin
            @(posedge clk);
            @(negedge clk);
            bus.req_valid = 2'b10;
            wait_res("bp", lat, ok);
            if (ok) begin
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    #1;
                    check("bp", "valid_held", 32'(bus.res_valid), 32'd1);
                    check("bp", "data_held", 32'(bus.res_data), 32'h1E);
                    check("bp", "id_held", 32'(bus.res_id), 32'd0);
                    check("bp", "no_accept", 32'(bus.req_ready), 32'd0);
                end
                bus.res_ready = 1'b1;
                @(negedge clk);
                bus.res_ready = 1'b0;
                #1;
                check("bp", "released", 32'(bus.res_valid), 32'd0);
                check("bp", "resume_grant", 32'(bus.req_ready), 32'd2);
                @(posedge clk);
                @(negedge clk);
                bus.req_valid = 2'b00;
                wait_res("bp2", lat, ok);
                if (ok) begin
                    check("bp2", "res_data", 32'(bus.res_data), 32'h0F);
                    check("bp2", "res_id", 32'(bus.res_id), 32'd1);
                    bus.res_ready = 1'b1;
                    @(negedge clk);
                    bus.res_ready = 1'b0;
                end
            end
        end
        bus.req_valid = 2'b00;
        model_rr = 1'b1;

        // Reset pulse while an op is executing drops it.
        @(negedge clk);
        bus.req_op0   = OP_SLL;
        bus.req_a0    = 8'h0F;
        bus.req_b0    = 8'd3;
        bus.req_valid = 2'b01;
        wait_ready("rst_exec", ok);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 2'b00;
        rst = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        model_rr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_exec", "no_result", 32'(bus.res_valid), 32'd0);
        end
        run_txn("post_rst", vecs[0], 1);

        // Randomized traffic against the reference model.
        for (int t = 0; t < 150; t++) begin
            v.vm  = 2'($urandom_range(1, 3));
            v.op0 = 2'($urandom);
            v.a0  = 8'($urandom);
            v.b0  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
            v.op1 = 2'($urandom);
            v.a1  = 8'($urandom);
            v.b1  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
            if (v.vm == 2'b11) v.exp_id = ~model_rr;
            else               v.exp_id = (v.vm == 2'b10);
            if (v.exp_id) ref_shift(v.op1, v.a1, v.b1, v.exp_d, v.exp_e);
            else          ref_shift(v.op0, v.a0, v.b0, v.exp_d, v.exp_e);
            run_txn($sformatf("rand%0d", t), v, 32'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
